// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned OPC_MSB   = 15;
    localparam int unsigned OPC_LSB   = 11;
    localparam logic [4:0]  OPC_HLT   = 5'b00001;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_HALTED
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold, or insert a bubble (valid=0, NOP, pc fields kept).
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PC_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  bubble_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    input  logic [PC_WIDTH-1:0]   pc_next_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [PC_WIDTH-1:0]   pc_next_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o   <= 1'b0;
            instr_o   <= DATA_WIDTH'(NOP_INSTR);
            pc_o      <= '0;
            pc_next_o <= '0;
        end else if (bubble_i) begin
            valid_o <= 1'b0;
            instr_o <= DATA_WIDTH'(NOP_INSTR);
        end else if (load_i) begin
            valid_o   <= 1'b1;
            instr_o   <= instr_i;
            pc_o      <= pc_i;
            pc_next_o <= pc_next_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request handshake, IF/ID register, HLT handling.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 16,
    parameter int unsigned          PC_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned          PC_INC     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic                  imem_req_o,
    output logic [PC_WIDTH-1:0]   imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  imem_ready_i,
    output logic                  if_id_valid_o,
    output logic [DATA_WIDTH-1:0] if_id_instr_o,
    output logic [PC_WIDTH-1:0]   if_id_pc_o,
    output logic [PC_WIDTH-1:0]   if_id_pc_next_o,
    output logic                  halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt_o,
    output logic [31:0]           perf_stall_cnt_o
`endif
);

    localparam logic [PC_WIDTH-1:0] PcInc = PC_WIDTH'(PC_INC);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                halted_q, halted_d;
    logic                accept;
    logic                is_hlt;
    logic                ifid_load;
    logic                ifid_bubble;
    logic [PC_WIDTH-1:0] pc_plus;

    assign imem_req_o  = (state_q == FS_RUN) && !stall_i && !redirect_i;
    assign imem_addr_o = pc_q;
    assign accept      = imem_req_o && imem_ready_i;
    assign is_hlt      = (imem_rdata_i[OPC_MSB:OPC_LSB] == OPC_HLT);
    assign pc_plus     = pc_q + PcInc;
    assign halted_o    = halted_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        halted_d    = halted_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (redirect_i) begin
            pc_d        = redirect_pc_i;
            ifid_bubble = 1'b1;
            state_d     = FS_RUN;
            halted_d    = 1'b0;
        end else begin
            if (state_q == FS_IDLE) begin
                state_d = FS_RUN;
            end
            if (flush_i) begin
                ifid_bubble = 1'b1;
            end else if (stall_i) begin
                ifid_bubble = 1'b0;
            end else if (accept) begin
                ifid_load = 1'b1;
                if (is_hlt) begin
                    // PC stays on the HLT so a later redirect is the only way forward.
                    state_d  = FS_HALTED;
                    halted_d = 1'b1;
                end else begin
                    pc_d = pc_plus;
                end
            end else begin
                ifid_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FS_IDLE;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .PC_WIDTH   (PC_WIDTH)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (ifid_load),
        .bubble_i  (ifid_bubble),
        .instr_i   (imem_rdata_i),
        .pc_i      (pc_q),
        .pc_next_i (pc_plus),
        .valid_o   (if_id_valid_o),
        .instr_o   (if_id_instr_o),
        .pc_o      (if_id_pc_o),
        .pc_next_o (if_id_pc_next_o)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (stall_i && (state_q == FS_RUN) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference model feeds an expected-IF/ID queue.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, redir, ready;
    logic [15:0] rpc;

    logic        req, valid, halted;
    logic [15:0] addr, rdata, instr, ifpc, ifpcn;
    logic        b_req, b_valid, b_halted;
    logic [15:0] b_addr, b_rdata, b_instr, b_pc, b_pcn;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        if (a == 16'h0007) return 16'h0800;
        return {4'h1, a[11:0]};
    endfunction

    assign rdata   = mem_f(addr);
    assign b_rdata = mem_f(b_addr);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] pf_a, ps_a, pf_b, ps_b;
`endif

    fetch_stage u_dut (
        .clk (clk), .rst_n (rst_n), .stall_i (stall), .flush_i (flush),
        .redirect_i (redir), .redirect_pc_i (rpc), .imem_req_o (req),
        .imem_addr_o (addr), .imem_rdata_i (rdata), .imem_ready_i (ready),
        .if_id_valid_o (valid), .if_id_instr_o (instr), .if_id_pc_o (ifpc),
        .if_id_pc_next_o (ifpcn), .halted_o (halted)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt_o (pf_a), .perf_stall_cnt_o (ps_a)
`endif
    );

    fetch_stage #(.RESET_PC (16'hFFFF)) u_dut_wrap (
        .clk (clk), .rst_n (rst_n), .stall_i (stall), .flush_i (flush),
        .redirect_i (redir), .redirect_pc_i (rpc), .imem_req_o (b_req),
        .imem_addr_o (b_addr), .imem_rdata_i (b_rdata), .imem_ready_i (ready),
        .if_id_valid_o (b_valid), .if_id_instr_o (b_instr), .if_id_pc_o (b_pc),
        .if_id_pc_next_o (b_pcn), .halted_o (b_halted)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt_o (pf_b), .perf_stall_cnt_o (ps_b)
`endif
    );

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pcn;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          m_state;   // 0 idle, 1 run, 2 halted
    logic [15:0] m_pc;
    logic        m_halted;
    logic        l_valid;
    logic [15:0] l_instr, l_pc, l_pcn;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_pc     = 16'h0000;
        m_halted = 1'b0;
        l_valid  = 1'b0;
        l_instr  = 16'h0000;
        l_pc     = 16'h0000;
        l_pcn    = 16'h0000;
        sb.delete();
    endtask

    task automatic check_cleared();
        check_eq("rst_req",     {31'd0, req},      32'd0);
        check_eq("rst_valid",   {31'd0, valid},    32'd0);
        check_eq("rst_instr",   {16'd0, instr},    32'd0);
        check_eq("rst_pc",      {16'd0, ifpc},     32'd0);
        check_eq("rst_pcn",     {16'd0, ifpcn},    32'd0);
        check_eq("rst_halted",  {31'd0, halted},   32'd0);
        check_eq("rstb_valid",  {31'd0, b_valid},  32'd0);
        check_eq("rstb_pc",     {16'd0, b_pc},     32'd0);
        check_eq("rstb_addr",   {16'd0, b_addr},   32'h0000FFFF);
        check_eq("rstb_halted", {31'd0, b_halted}, 32'd0);
    endtask

    // One clock: drive inputs, check request, step the model, check IF/ID after the edge.
    task automatic cyc(input logic st, input logic fl, input logic rd,
                       input logic [15:0] tgt, input logic rdy);
        logic        mreq;
        int          kind;      // 0 bubble, 1 hold, 2 load
        logic [15:0] w;
        exp_t        e;
        stall = st; flush = fl; redir = rd; rpc = tgt; ready = rdy;
        #1;
        mreq = (m_state == 1) && !st && !rd;
        check_eq("req", {31'd0, req}, {31'd0, mreq});
        if (mreq) check_eq("addr", {16'd0, addr}, {16'd0, m_pc});
        kind = 0;
        if (rd) begin
            m_pc = tgt; m_state = 1; m_halted = 1'b0;
        end else begin
            if (m_state == 0) m_state = 1;
            if (fl) kind = 0;
            else if (st) kind = 1;
            else if (mreq && rdy) begin
                kind = 2;
                w = mem_f(m_pc);
                sb.push_back({w, m_pc, m_pc + 16'd1});
                if (w[15:11] == 5'b00001) begin
                    m_state = 2; m_halted = 1'b1;
                end else begin
                    m_pc = m_pc + 16'd1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (kind == 2) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb_empty @%0t: got no entry expected one", $time);
            end else begin
                e = sb.pop_front();
                l_valid = 1'b1; l_instr = e.instr; l_pc = e.pc; l_pcn = e.pcn;
            end
        end else if (kind == 0) begin
            l_valid = 1'b0; l_instr = 16'h0000;
        end
        check_eq("valid",  {31'd0, valid},  {31'd0, l_valid});
        check_eq("instr",  {16'd0, instr},  {16'd0, l_instr});
        check_eq("pc",     {16'd0, ifpc},   {16'd0, l_pc});
        check_eq("pcn",    {16'd0, ifpcn},  {16'd0, l_pcn});
        check_eq("halted", {31'd0, halted}, {31'd0, m_halted});
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redir = 1'b0; rpc = 16'h0; ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cleared();
        rst_n = 1'b1;

        // T1 plus wrap instance: FFFF then 0000
        cyc(0, 0, 0, 16'h0, 1);
        check_eq("wrap_addr0", {16'd0, b_addr}, 32'h0000FFFF);
        cyc(0, 0, 0, 16'h0, 1);
        check_eq("wrap_pc0",    {16'd0, b_pc},    32'h0000FFFF);
        check_eq("wrap_pcn0",   {16'd0, b_pcn},   32'h00000000);
        check_eq("wrap_instr0", {16'd0, b_instr}, 32'h00001FFF);
        cyc(0, 0, 0, 16'h0, 1);
        check_eq("wrap_pc1",    {16'd0, b_pc},    32'h00000000);
        check_eq("wrap_instr1", {16'd0, b_instr}, 32'h00001000);
        cyc(0, 0, 0, 16'h0, 1);

        // T4: ready low at PC=3
        cyc(0, 0, 0, 16'h0, 0);
        cyc(0, 0, 0, 16'h0, 0);
        repeat (3) cyc(0, 0, 0, 16'h0, 1);

        // T2: stall with IF/ID at pc 5
        repeat (3) cyc(1, 0, 0, 16'h0, 1);
        cyc(0, 0, 0, 16'h0, 1);

        // T5: HLT at pc 7, idle/flush stay halted, redirect to 0 resumes
        cyc(0, 0, 0, 16'h0, 1);
        check_eq("hlt_instr", {16'd0, instr}, 32'h00000800);
        repeat (2) cyc(0, 0, 0, 16'h0, 1);
        cyc(0, 1, 0, 16'h0, 1);
        cyc(1, 0, 0, 16'h0, 1);
        cyc(0, 0, 1, 16'h0000, 1);
        repeat (3) cyc(0, 0, 0, 16'h0, 1);

        // T3: redirect with stall, flush while running, stall+flush, PC wrap
        cyc(1, 0, 1, 16'h0040, 1);
        repeat (2) cyc(0, 0, 0, 16'h0, 1);
        cyc(0, 1, 0, 16'h0, 1);
        cyc(0, 0, 0, 16'h0, 1);
        cyc(1, 1, 0, 16'h0, 1);
        cyc(0, 0, 1, 16'hFFFE, 1);
        repeat (3) cyc(0, 0, 0, 16'h0, 1);

        for (int i = 0; i < 60; i++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 11) == 0), 16'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0));
        end

        // T6: async reset mid-stall
        cyc(0, 0, 0, 16'h0, 1);
        cyc(1, 0, 0, 16'h0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared();
        #2;
        rst_n = 1'b1;
        model_reset();
        repeat (4) cyc(0, 0, 0, 16'h0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
